// File: rtl/legv8_ctrl_fsm_if.sv
// Control-unit bus: instruction/memory status in, datapath control word out.
// The FSM drives through the master modport; the datapath/memory side uses slave.
interface legv8_ctrl_fsm_if #(
  parameter int REG_AW = 5,
  parameter int K_W    = 64
);
  logic [31:0]       Inst;
  logic              mem_ready;
  logic              zero_flag;
  logic [REG_AW-1:0] DA;
  logic [REG_AW-1:0] AA;
  logic [REG_AW-1:0] BA;
  logic [4:0]        FS;
  logic [K_W-1:0]    K;
  logic [1:0]        PC_SEL;
  logic              WR;
  logic              IL;
  logic              RCS;
  logic              RR;
  logic              WRR;
  logic              EN_ALU;
  logic              EN_B;
  logic              EN_K;
  logic              addr_sel;
  logic              Cin;
  logic              SFL;
  logic [2:0]        state;
  logic              illegal;
  logic              timeout;

  modport master (
    input  Inst, mem_ready, zero_flag,
    output DA, AA, BA, FS, K, PC_SEL, WR, IL, RCS, RR, WRR,
           EN_ALU, EN_B, EN_K, addr_sel, Cin, SFL, state, illegal, timeout
  );

  modport slave (
    output Inst, mem_ready, zero_flag,
    input  DA, AA, BA, FS, K, PC_SEL, WR, IL, RCS, RR, WRR,
           EN_ALU, EN_B, EN_K, addr_sel, Cin, SFL, state, illegal, timeout
  );
endinterface

// File: rtl/legv8_ctrl_fsm.sv
// Multicycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB) with B/CBZ, a
// variable-latency memory handshake, a wait timeout and illegal-opcode trapping.
module legv8_ctrl_fsm #(
  parameter int REG_AW  = 5,
  parameter int K_W     = 64,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             Reset,
  legv8_ctrl_fsm_if.master bus
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_I, C_SH, C_LD, C_ST, C_B, C_CBZ
  } cls_t;

  state_t          r_state;
  logic [31:0]     r_inst;
  logic [WW-1:0]   r_wait;
  logic            r_illegal;
  logic            r_timeout;

  function automatic cls_t op_class(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
      11'b11001010000, 11'b11101010000, 11'b10101011000, 11'b11101011000: return C_R;
      11'b1001000100?, 11'b1101000100?, 11'b1001001000?, 11'b1011001000?,
      11'b1101001000?:                                                    return C_I;
      11'b1101001101?:                                                    return C_SH;
      11'b11111000010:                                                    return C_LD;
      11'b11111000000:                                                    return C_ST;
      11'b000101?????:                                                    return C_B;
      11'b10110100???:                                                    return C_CBZ;
      default:                                                            return C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] op_fs(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b10101011000, 11'b1001000100?,
      11'b11111000010, 11'b11111000000:                  return 5'b01000;
      11'b11001011000, 11'b11101011000, 11'b1101000100?: return 5'b01001;
      11'b10001010000, 11'b11101010000, 11'b1001001000?: return 5'b00000;
      11'b10101010000, 11'b1011001000?:                  return 5'b00100;
      11'b11001010000, 11'b1101001000?:                  return 5'b01100;
      11'b11010011011:                                   return 5'b10000;
      11'b11010011010:                                   return 5'b10100;
      default:                                           return 5'b00000;
    endcase
  endfunction

  // Constant field selection with zero/sign fill up to K_W.
  function automatic logic [K_W-1:0] k_of(input cls_t cls, input logic [31:0] ins);
    case (cls)
      C_I:        return {{(K_W-12){1'b0}}, ins[21:10]};
      C_SH:       return {{(K_W-6){1'b0}}, ins[15:10]};
      C_LD, C_ST: return {{(K_W-9){ins[20]}}, ins[20:12]};
      C_B:        return {{(K_W-26){ins[25]}}, ins[25:0]};
      C_CBZ:      return {{(K_W-19){ins[23]}}, ins[23:5]};
      default:    return '0;
    endcase
  endfunction

  logic [10:0]       w_op;
  cls_t              w_cls;
  logic [4:0]        w_fs;
  logic [K_W-1:0]    w_kval;
  logic              w_sfl_op;
  logic              w_abort;
  logic [WW-1:0]     w_wait_nx;
  logic [REG_AW-1:0] w_rd, w_rn, w_rm;

  assign w_op      = r_inst[31:21];
  assign w_cls     = op_class(w_op);
  assign w_fs      = op_fs(w_op);
  assign w_kval    = k_of(w_cls, r_inst);
  assign w_sfl_op  = (w_op == 11'b11101010000) || (w_op == 11'b10101011000) ||
                     (w_op == 11'b11101011000);
  assign w_abort   = ((r_state == S_FETCH) || (r_state == S_MEM)) && (r_wait == WW'(TIMEOUT));
  assign w_wait_nx = (r_wait == WW'(TIMEOUT)) ? r_wait : r_wait + WW'(1);
  assign w_rd      = REG_AW'(r_inst[4:0]);
  assign w_rn      = REG_AW'(r_inst[9:5]);
  assign w_rm      = REG_AW'(r_inst[20:16]);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_FETCH;
      r_inst    <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_abort) begin
            r_timeout <= 1'b1;
            r_wait    <= '0;
          end else if (bus.mem_ready) begin
            r_inst  <= bus.Inst;
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else begin
            r_wait <= w_wait_nx;
          end
        end
        S_DECODE: begin
          if (w_cls == C_ILL) begin
            r_illegal <= 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC:  r_state <= ((w_cls == C_LD) || (w_cls == C_ST)) ? S_MEM : S_FETCH;
        S_MEM: begin
          if (w_abort) begin
            r_timeout <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_FETCH;
          end else if (bus.mem_ready) begin
            r_wait  <= '0;
            r_state <= (w_cls == C_LD) ? S_WB : S_FETCH;
          end else begin
            r_wait <= w_wait_nx;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  logic [REG_AW-1:0] w_da, w_aa, w_ba;
  logic [4:0]        w_fs_o;
  logic [K_W-1:0]    w_k;
  logic [1:0]        w_pc_sel;
  logic w_wr, w_il, w_rcs, w_rr, w_wrr, w_en_alu, w_en_b, w_en_k, w_addr_sel, w_cin, w_sfl;

  always_comb begin
    w_da = '0; w_aa = '0; w_ba = '0; w_fs_o = '0; w_k = '0; w_pc_sel = 2'b00;
    w_wr = 1'b0; w_il = 1'b0; w_rcs = 1'b0; w_rr = 1'b0; w_wrr = 1'b0;
    w_en_alu = 1'b0; w_en_b = 1'b0; w_en_k = 1'b0; w_addr_sel = 1'b0;
    w_cin = 1'b0; w_sfl = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!w_abort) begin
          w_rcs = 1'b1; w_rr = 1'b1; w_il = 1'b1;
        end
      end
      S_DECODE: if (w_cls == C_ILL) w_pc_sel = 2'b01;
      S_EXEC: begin
        case (w_cls)
          C_R, C_I, C_SH: begin
            w_da = w_rd; w_aa = w_rn; w_ba = (w_cls == C_SH) ? '0 : w_rm;
            w_en_alu = 1'b1; w_wr = 1'b1; w_pc_sel = 2'b01; w_fs_o = w_fs;
            w_cin = (w_fs == 5'b01001); w_sfl = w_sfl_op;
            w_en_k = (w_cls != C_R); w_k = w_kval;
          end
          C_LD, C_ST: begin
            w_aa = w_rn; w_en_k = 1'b1; w_k = w_kval; w_fs_o = 5'b01000;
          end
          C_B: begin
            w_k = w_kval; w_pc_sel = 2'b10;
          end
          C_CBZ: begin
            w_ba = w_rd; w_k = w_kval; w_pc_sel = bus.zero_flag ? 2'b10 : 2'b01;
          end
          default: ;
        endcase
      end
      // Address operands stay on the ALU for the whole memory wait.
      S_MEM: begin
        if (!w_abort) begin
          w_rcs = 1'b1; w_addr_sel = 1'b1; w_aa = w_rn; w_en_k = 1'b1;
          w_k = w_kval; w_fs_o = 5'b01000;
          if (w_cls == C_ST) begin
            w_wrr = 1'b1; w_en_b = 1'b1; w_ba = w_rd;
            if (bus.mem_ready) w_pc_sel = 2'b01;
          end else begin
            w_rr = 1'b1;
          end
        end
      end
      S_WB: begin
        w_rr = 1'b1; w_rcs = 1'b1; w_da = w_rd; w_wr = 1'b1; w_pc_sel = 2'b01;
      end
      default: ;
    endcase
  end

  // Write strobes are masked while Reset is high so an aborted access commits nothing.
  assign bus.DA       = w_da;
  assign bus.AA       = w_aa;
  assign bus.BA       = w_ba;
  assign bus.FS       = w_fs_o;
  assign bus.K        = w_k;
  assign bus.PC_SEL   = w_pc_sel;
  assign bus.WR       = w_wr  & ~Reset;
  assign bus.WRR      = w_wrr & ~Reset;
  assign bus.SFL      = w_sfl & ~Reset;
  assign bus.IL       = w_il;
  assign bus.RCS      = w_rcs;
  assign bus.RR       = w_rr;
  assign bus.EN_ALU   = w_en_alu;
  assign bus.EN_B     = w_en_b;
  assign bus.EN_K     = w_en_k;
  assign bus.addr_sel = w_addr_sel;
  assign bus.Cin      = w_cin;
  assign bus.state    = r_state;
  assign bus.illegal  = r_illegal;
  assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_legv8_ctrl_fsm.sv
// Directed bench for legv8_ctrl_fsm: hand-computed control words per instruction.
module tb_legv8_ctrl_fsm;
  logic CLK = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  legv8_ctrl_fsm_if #(.REG_AW(5), .K_W(64)) bus ();

  legv8_ctrl_fsm #(.REG_AW(5), .K_W(64), .TIMEOUT(6)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hand one instruction over in FETCH; returns with the FSM in DECODE.
  task automatic fetch(input logic [31:0] ins);
    bus.Inst      = ins;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.Inst      = 32'h0;
    #1;
  endtask

  initial begin
    Reset = 1'b1; bus.Inst = 32'h0; bus.mem_ready = 1'b0; bus.zero_flag = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("rst_state",  64'(bus.state),   64'd0);
    chk("rst_rr",     64'(bus.RR),      64'd1);
    chk("rst_il",     64'(bus.IL),      64'd1);
    chk("rst_wr",     64'(bus.WR),      64'd0);
    chk("rst_pcsel",  64'(bus.PC_SEL),  64'd0);
    chk("rst_illeg",  64'(bus.illegal), 64'd0);
    chk("rst_tmo",    64'(bus.timeout), 64'd0);

    // ADDI X1,X2,#5
    fetch(32'h91001441);
    chk("addi_dec_state", 64'(bus.state),  64'd1);
    chk("addi_dec_pcsel", 64'(bus.PC_SEL), 64'd0);
    tick();
    chk("addi_state", 64'(bus.state),  64'd2);
    chk("addi_da",    64'(bus.DA),     64'd1);
    chk("addi_aa",    64'(bus.AA),     64'd2);
    chk("addi_k",     bus.K,           64'd5);
    chk("addi_fs",    64'(bus.FS),     64'b01000);
    chk("addi_wr",    64'(bus.WR),     64'd1);
    chk("addi_enk",   64'(bus.EN_K),   64'd1);
    chk("addi_pcsel", 64'(bus.PC_SEL), 64'd1);
    tick();
    chk("addi_back",  64'(bus.state),  64'd0);

    // SUBS X1,X2,X3
    fetch(32'hEB030041);
    tick();
    chk("subs_fs",  64'(bus.FS),   64'b01001);
    chk("subs_cin", 64'(bus.Cin),  64'd1);
    chk("subs_sfl", 64'(bus.SFL),  64'd1);
    chk("subs_ba",  64'(bus.BA),   64'd3);
    chk("subs_enk", 64'(bus.EN_K), 64'd0);
    tick();
    chk("subs_sfl_off", 64'(bus.SFL), 64'd0);

    // LSL X9,X10,#3
    fetch(32'hD3600D49);
    tick();
    chk("lsl_fs", 64'(bus.FS), 64'b10000);
    chk("lsl_k",  bus.K,       64'd3);
    chk("lsl_da", 64'(bus.DA), 64'd9);
    chk("lsl_aa", 64'(bus.AA), 64'd10);
    tick();

    // LDUR X3,[X4,#-8] with four wait cycles in MEM
    fetch(32'hF85F8083);
    tick();
    chk("ldur_state", 64'(bus.state),  64'd2);
    chk("ldur_k",     bus.K,           64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_aa",    64'(bus.AA),     64'd4);
    chk("ldur_fs",    64'(bus.FS),     64'b01000);
    chk("ldur_wr_ex", 64'(bus.WR),     64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ldur_mem_state", 64'(bus.state),    64'd3);
      chk("ldur_mem_rr",    64'(bus.RR),       64'd1);
      chk("ldur_mem_asel",  64'(bus.addr_sel), 64'd1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("ldur_mem_pcsel", 64'(bus.PC_SEL), 64'd0);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("ldur_wb_state", 64'(bus.state),  64'd4);
    chk("ldur_wb_wr",    64'(bus.WR),     64'd1);
    chk("ldur_wb_da",    64'(bus.DA),     64'd3);
    chk("ldur_wb_pcsel", 64'(bus.PC_SEL), 64'd1);
    tick();
    chk("ldur_back", 64'(bus.state), 64'd0);

    // STUR X7,[X8,#16] with zero wait: 4 cycles
    fetch(32'hF8010107);
    tick();
    chk("stur_k", bus.K, 64'd16);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("stur_wrr",   64'(bus.WRR),    64'd1);
    chk("stur_enb",   64'(bus.EN_B),   64'd1);
    chk("stur_ba",    64'(bus.BA),     64'd7);
    chk("stur_pcsel", 64'(bus.PC_SEL), 64'd1);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("stur_back", 64'(bus.state), 64'd0);

    // CBZ X5, imm19=16
    fetch(32'hB4000205);
    tick();
    bus.zero_flag = 1'b1;
    #1;
    chk("cbz_k",       bus.K,           64'd16);
    chk("cbz_ba",      64'(bus.BA),     64'd5);
    chk("cbz_taken",   64'(bus.PC_SEL), 64'd2);
    bus.zero_flag = 1'b0;
    #1;
    chk("cbz_nottkn",  64'(bus.PC_SEL), 64'd1);
    chk("cbz_wr",      64'(bus.WR),     64'd0);
    tick();

    // B -1 (all-ones offset)
    fetch(32'h17FFFFFF);
    tick();
    chk("b_k",     bus.K,           64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_pcsel", 64'(bus.PC_SEL), 64'd2);
    tick();

    // Illegal opcode 0x7FF
    fetch(32'hFFE00000);
    chk("ill_dec_pcsel", 64'(bus.PC_SEL), 64'd1);
    chk("ill_dec_wr",    64'(bus.WR),     64'd0);
    chk("ill_dec_wrr",   64'(bus.WRR),    64'd0);
    tick();
    chk("ill_state", 64'(bus.state),   64'd0);
    chk("ill_flag",  64'(bus.illegal), 64'd1);

    // mem_ready stuck low in FETCH: TIMEOUT=6 waits then one aborted cycle
    for (int i = 0; i < 6; i++) begin
      chk("tmo_wait_rr", 64'(bus.RR), 64'd1);
      tick();
    end
    chk("tmo_abort_rr",  64'(bus.RR),      64'd0);
    chk("tmo_abort_il",  64'(bus.IL),      64'd0);
    chk("tmo_abort_flg", 64'(bus.timeout), 64'd0);
    tick();
    chk("tmo_flag",  64'(bus.timeout), 64'd1);
    chk("tmo_state", 64'(bus.state),   64'd0);
    chk("tmo_rr",    64'(bus.RR),      64'd1);

    // Reset pulse during a STUR memory wait
    fetch(32'hF8010107);
    tick(); tick();
    chk("rstmem_state", 64'(bus.state), 64'd3);
    chk("rstmem_wrr",   64'(bus.WRR),   64'd1);
    Reset = 1'b1;
    #1;
    chk("rstmem_wrr_gated", 64'(bus.WRR), 64'd0);
    tick();
    Reset = 1'b0;
    #1;
    chk("rstmem_after_state", 64'(bus.state),   64'd0);
    chk("rstmem_after_wrr",   64'(bus.WRR),     64'd0);
    chk("rstmem_after_ill",   64'(bus.illegal), 64'd0);
    chk("rstmem_after_tmo",   64'(bus.timeout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
